rv_alu_mc: RTL and testbench
============================

# rv_alu_mc

Parametrised, registered integer ALU for the rv_core execute stage. It extends the single-cycle 32-bit combinational ALU to an XLEN-wide unit with an issue/complete handshake. Simple ops finish in one cycle, the multiply family is a two-stage pipeline, and the divide/remainder family is an in-block radix-2 iterative divider. The block stalls on `rdy` and drives `cmpl` to the writeback/hazard logic.

## Interface
- `XLEN`, 32: operand/result width; legal values 32 or 64.
- `SHW`, $clog2(XLEN): shift-amount width; the shift count is `rrd2[SHW-1:0]`.

- `clk` in 1: core clock.
- `xreset` in 1: asynchronous, active-low reset.
- `rdy` in 1: pipeline advance; 0 freezes all internal state and outputs.
- `start` in 1: issue strobe; an op is accepted when `start & rdy & !busy`.
- `alu` in alu_t: operation code from pkg_rv_decode.
- `rrd1` in XLEN: operand 1.
- `rrd2` in XLEN: operand 2.
- `rwdat` out XLEN: registered result; valid when `cmpl`=1.
- `busy` out 1: a multi-cycle op is in flight; new issues are refused.
- `cmpl` out 1: one-cycle pulse (while `rdy`=1) marking a valid `rwdat`.
- `mulop` out 1: the accepted op is in the MUL/DIV group; registered and held until `cmpl`.

## Operation
- FSM states: IDLE, MUL2, DIV, DFIX. `busy` = (state != IDLE).
- Simple ops: ADD, SUB, S2 (pass `rrd2`), SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA.
  - Computed at issue and registered into `rwdat`.
  - `cmpl`=1 next cycle. State stays IDLE.
  - Shifts mask the count to SHW bits. SRA is arithmetic on XLEN. SLT/SLTU produce 0 or 1 zero-extended.
- MUL, MULH, MULHSU, MULHU:
  - Issue registers sign-extended XLEN+1-bit operands, then goes to MUL2.
  - MUL2 forms the 2·XLEN product, writes the low half (MUL) or high half (others) to `rwdat`, pulses `cmpl`, and returns to IDLE.
- DIV, DIVU, REM, REMU:
  - Issue latches operand magnitudes and the sign flags, clears the remainder, sets the counter to XLEN, and goes to DIV.
  - DIV runs one restoring shift-subtract step per cycle. When the counter reaches 0 the FSM goes to DFIX.
  - DFIX applies sign correction (quotient sign = s1^s2, remainder sign = s1), writes the quotient or remainder, pulses `cmpl`, and returns to IDLE.
- Special cases are resolved at issue with simple-op latency; the FSM stays IDLE.
  - Divide by zero: quotient = all ones; remainder = `rrd1`.
  - Signed overflow (most-negative ÷ −1): quotient = most-negative; remainder = 0.
- Unknown or unimplemented `alu` codes: `rwdat`=0 with simple-op latency.
- `start` while `busy`: ignored, with no side effect on the op in flight.
- `start` in the same cycle as `cmpl` from IDLE: accepted, so back-to-back simple ops give one result per cycle.

## Timing
- Reset values: `rwdat`=0, `cmpl`=0, `busy`=0, `mulop`=0, state IDLE, counter 0.
- Latency counts from the issue edge k:
  - Simple ops and div special cases: `cmpl` at k+1.
  - MUL group: `cmpl` at k+2.
  - DIV group: `cmpl` at k+XLEN+2, so 34 cycles for XLEN=32.
- `busy` rises at k+1 for multi-cycle ops and falls in the `cmpl` cycle.
- `rdy`=0: counter, state, operands and `rwdat` hold. `cmpl` is forced to 0 and reasserts once `rdy` returns.
- Reset asserted mid-op: the op is aborted immediately and all outputs take their reset values. No `cmpl` is produced for that op.
- `rwdat` holds its last value between completions.

## Configuration
- `RV_ALU_ZBB_EN` defined:
  - Adds the single-cycle ops MIN, MAX, MINU, MAXU, ANDN, ORN and XNOR, using the pkg_rv_decode enumerators.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned.
  - ANDN = `rrd1 & ~rrd2`, ORN = `rrd1 | ~rrd2`, XNOR = `~(rrd1 ^ rrd2)`.
- `RV_ALU_ZBB_EN` undefined: those codes fall into the default case (`rwdat`=0, latency 1) and no comparator logic is synthesised for them.

## Test plan
- XLEN=32, ADD 0xFFFFFFFF+1 then SRA 0x80000000 by 0x24 back-to-back → `cmpl` at k+1 and k+2; results 0x00000000 and 0xF8000000 (count masked to 4).
- MULH with 0x80000000 × 0x80000000 → `rwdat`=0x40000000 at k+2; MULHSU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 ÷ 2 → `cmpl` at k+34, `rwdat`=0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. `start` pulsed mid-divide is ignored.
- DIVU 5 ÷ 0 → 0xFFFFFFFF at k+1. REM 0x80000000 ÷ −1 → 0 at k+1. `busy` never asserts.
- During a DIVU, hold `rdy`=0 for 5 cycles → `cmpl` moves to k+39 with the correct quotient. Pulse `xreset` during a second divide → outputs return to 0 and no `cmpl` follows.
- XLEN=64 with `RV_ALU_ZBB_EN`: MIN of −1 and 1 → 0xFFFFFFFFFFFFFFFF, MAXU of the same operands → −1, DIVU latency = 66 cycles. Without the macro: MIN → 0.

Source files
------------

// File: rtl/rv_alu_mc.sv
// rv_alu_mc: registered XLEN-wide integer ALU with a 2-stage multiplier and an iterative radix-2 divider.
// Optional Zbb ops (MIN/MAX/MINU/MAXU/ANDN/ORN/XNOR) are built only when RV_ALU_ZBB_EN is defined.
package pkg_rv_decode;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_S2, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_MIN, ALU_MAX, ALU_MINU, ALU_MAXU, ALU_ANDN, ALU_ORN, ALU_XNOR
  } alu_t;
endpackage

module rv_alu_mc
  import pkg_rv_decode::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            xreset,
  input  logic            rdy,
  input  logic            start,
  input  alu_t            alu,
  input  logic [XLEN-1:0] rrd1,
  input  logic [XLEN-1:0] rrd2,
  output logic [XLEN-1:0] rwdat,
  output logic            busy,
  output logic            cmpl,
  output logic            mulop
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL2, DIV, DFIX} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_rwdat;
  logic            r_cmpl;
  logic            r_mulop;
  logic [XLEN:0]   r_ma, r_mb;
  logic            r_mlo;
  logic [XLEN-1:0] r_quo, r_rem, r_dvs;
  logic            r_s1, r_s2, r_isrem;
  logic [CW-1:0]   r_cnt;

  logic            w_issue, w_is_mul, w_is_div, w_div_signed, w_div_rem;
  logic            w_div_zero, w_div_ovf, w_div_special;
  logic            w_slt, w_sltu, w_s1, w_s2;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_simple, w_special, w_mag1, w_mag2;
  logic [2*XLEN-1:0] w_ea, w_eb, w_prod;
  logic [XLEN:0]   w_rsh, w_dif;
  logic            w_ge;
  logic [XLEN-1:0] w_qfix, w_rfix;

  assign w_issue      = start & rdy & (r_state == IDLE);
  assign w_is_mul     = alu inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign w_is_div     = alu inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign w_div_signed = (alu == ALU_DIV) | (alu == ALU_REM);
  assign w_div_rem    = (alu == ALU_REM) | (alu == ALU_REMU);
  assign w_div_zero   = (rrd2 == '0);
  assign w_div_ovf    = w_div_signed & (rrd1 == MOST_NEG) & (rrd2 == '1);
  assign w_div_special = w_is_div & (w_div_zero | w_div_ovf);

  assign w_slt   = $signed(rrd1) < $signed(rrd2);
  assign w_sltu  = rrd1 < rrd2;
  assign w_shamt = rrd2[SHW-1:0];

  // Single-cycle result; any code not listed (including the Zbb codes when disabled) yields zero.
  always_comb begin
    w_simple = '0;
    case (alu)
      ALU_ADD:  w_simple = rrd1 + rrd2;
      ALU_SUB:  w_simple = rrd1 - rrd2;
      ALU_S2:   w_simple = rrd2;
      ALU_SLT:  w_simple = {{(XLEN-1){1'b0}}, w_slt};
      ALU_SLTU: w_simple = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_XOR:  w_simple = rrd1 ^ rrd2;
      ALU_OR:   w_simple = rrd1 | rrd2;
      ALU_AND:  w_simple = rrd1 & rrd2;
      ALU_SLL:  w_simple = rrd1 << w_shamt;
      ALU_SRL:  w_simple = rrd1 >> w_shamt;
      ALU_SRA:  w_simple = $signed(rrd1) >>> w_shamt;
`ifdef RV_ALU_ZBB_EN
      ALU_MIN:  w_simple = w_slt  ? rrd1 : rrd2;
      ALU_MAX:  w_simple = w_slt  ? rrd2 : rrd1;
      ALU_MINU: w_simple = w_sltu ? rrd1 : rrd2;
      ALU_MAXU: w_simple = w_sltu ? rrd2 : rrd1;
      ALU_ANDN: w_simple = rrd1 & ~rrd2;
      ALU_ORN:  w_simple = rrd1 | ~rrd2;
      ALU_XNOR: w_simple = ~(rrd1 ^ rrd2);
`endif
      default:  w_simple = '0;
    endcase
  end

  always_comb begin
    w_special = '0;
    if (w_div_zero)
      w_special = w_div_rem ? rrd1 : '1;
    else if (w_div_ovf)
      w_special = w_div_rem ? '0 : MOST_NEG;
  end

  assign w_s1   = w_div_signed & rrd1[XLEN-1];
  assign w_s2   = w_div_signed & rrd2[XLEN-1];
  assign w_mag1 = w_s1 ? -rrd1 : rrd1;
  assign w_mag2 = w_s2 ? -rrd2 : rrd2;

  // Explicit sign extension to 2*XLEN makes the low 2*XLEN bits of a plain product exact.
  assign w_ea   = {{(XLEN-1){r_ma[XLEN]}}, r_ma};
  assign w_eb   = {{(XLEN-1){r_mb[XLEN]}}, r_mb};
  assign w_prod = w_ea * w_eb;

  // Restoring step: the extra top bit of the difference is the borrow.
  assign w_rsh  = {r_rem, r_quo[XLEN-1]};
  assign w_dif  = w_rsh - {1'b0, r_dvs};
  assign w_ge   = ~w_dif[XLEN];
  assign w_qfix = (r_s1 ^ r_s2) ? -r_quo : r_quo;
  assign w_rfix = r_s1 ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rdy) begin
      case (r_state)
        IDLE: begin
          if (w_issue && w_is_mul)
            w_state_nxt = MUL2;
          else if (w_issue && w_is_div && !w_div_special)
            w_state_nxt = DIV;
        end
        MUL2:    w_state_nxt = IDLE;
        DIV:     if (r_cnt == CW'(1)) w_state_nxt = DFIX;
        DFIX:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath registers; everything freezes while rdy is low.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_rwdat <= '0;
      r_cmpl  <= 1'b0;
      r_mulop <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_mlo   <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_isrem <= 1'b0;
      r_cnt   <= '0;
    end else if (rdy) begin
      r_cmpl <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_mulop <= w_is_mul | w_is_div;
            if (w_is_mul) begin
              r_ma  <= {(alu != ALU_MULHU) & rrd1[XLEN-1], rrd1};
              r_mb  <= {((alu == ALU_MUL) | (alu == ALU_MULH)) & rrd2[XLEN-1], rrd2};
              r_mlo <= (alu == ALU_MUL);
            end else if (w_is_div && !w_div_special) begin
              r_quo   <= w_mag1;
              r_dvs   <= w_mag2;
              r_rem   <= '0;
              r_s1    <= w_s1;
              r_s2    <= w_s2;
              r_isrem <= w_div_rem;
              r_cnt   <= CW'(XLEN);
            end else begin
              r_rwdat <= w_is_div ? w_special : w_simple;
              r_cmpl  <= 1'b1;
            end
          end else begin
            r_mulop <= 1'b0;
          end
        end
        MUL2: begin
          r_rwdat <= r_mlo ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
          r_cmpl  <= 1'b1;
        end
        DIV: begin
          r_rem <= w_ge ? w_dif[XLEN-1:0] : w_rsh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        DFIX: begin
          r_rwdat <= r_isrem ? w_rfix : w_qfix;
          r_cmpl  <= 1'b1;
        end
        default: r_cmpl <= 1'b0;
      endcase
    end
  end

  assign rwdat = r_rwdat;
  assign busy  = (r_state != IDLE);
  assign cmpl  = r_cmpl & rdy;
  assign mulop = r_mulop;

endmodule

// File: tb/tb_rv_alu_mc.sv
// tb_rv_alu_mc: vector table plus scoreboard queue for rv_alu_mc at XLEN=32.
// Expected results are queued at issue and checked when cmpl pulses.
module tb_rv_alu_mc;
  import pkg_rv_decode::*;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic        rdy = 1'b1;
  logic        start = 1'b0;
  alu_t        alu = ALU_ADD;
  logic [31:0] rrd1 = '0;
  logic [31:0] rrd2 = '0;
  logic [31:0] rwdat;
  logic        busy, cmpl, mulop;

  rv_alu_mc #(.XLEN(32)) dut (
    .clk(clk), .xreset(xreset), .rdy(rdy), .start(start), .alu(alu),
    .rrd1(rrd1), .rrd2(rrd2), .rwdat(rwdat), .busy(busy), .cmpl(cmpl), .mulop(mulop)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    alu_t        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          k;
    logic        md;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic isMd(input alu_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  task automatic addVec(input string n, input alu_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op on the next edge and queue its expected completion.
  task automatic applyStimulus(input string n, input alu_t op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] e, input int lat);
    sb_t s;
    start = 1'b1; alu = op; rrd1 = a; rrd2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    s.name = n; s.res = e; s.lat = lat; s.k = cyc; s.md = isMd(op);
    sbq.push_back(s);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (xreset && cmpl) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL spurious_cmpl: got rwdat %h want no completion", rwdat);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        checkOutput({e.name, "_res"}, 64'(rwdat), 64'(e.res));
        checkOutput({e.name, "_lat"}, 64'(cyc - e.k + 1), 64'(e.lat));
        checkOutput({e.name, "_mulop"}, 64'(mulop), 64'(e.md));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    addVec("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    addVec("sra_mask", ALU_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
    addVec("sub",      ALU_SUB,  32'h5,         32'h7,         32'hFFFF_FFFE, 1);
    addVec("s2",       ALU_S2,   32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1);
    addVec("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1);
    addVec("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    addVec("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    addVec("or",       ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1);
    addVec("and",      ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    addVec("sll_mask", ALU_SLL,  32'h1,         32'h21,        32'h2,         1);
    addVec("srl",      ALU_SRL,  32'h8000_0000, 32'd31,        32'h1,         1);
    addVec("unknown",  alu_t'(5'd31), 32'h1234, 32'h5678,      32'h0,         1);
`ifdef RV_ALU_ZBB_EN
    addVec("min",      ALU_MIN,  32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1);
    addVec("maxu",     ALU_MAXU, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1);
`else
    addVec("min",      ALU_MIN,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    addVec("maxu",     ALU_MAXU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
`endif
    addVec("mul",      ALU_MUL,    32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 2);
    addVec("mulh",     ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    addVec("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    addVec("mulhu",    ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    addVec("rem_neg",  ALU_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34);
    addVec("divu",     ALU_DIVU, 32'd100,       32'd7,         32'd14,        34);
    addVec("remu",     ALU_REMU, 32'd100,       32'd7,         32'd2,         34);
    addVec("div_nd",   ALU_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    addVec("rem_nd",   ALU_REM,  32'd7,         32'hFFFF_FFFE, 32'h1,         34);
    addVec("divu_z",   ALU_DIVU, 32'd5,         32'h0,         32'hFFFF_FFFF, 1);
    addVec("rem_ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    addVec("div_ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    addVec("rem_z",    ALU_REM,  32'd7,         32'h0,         32'd7,         1);

    #12;
    checkOutput("rst_rwdat", 64'(rwdat), 64'h0);
    checkOutput("rst_cmpl",  64'(cmpl),  64'h0);
    checkOutput("rst_busy",  64'(busy),  64'h0);
    checkOutput("rst_mulop", 64'(mulop), 64'h0);
    @(negedge clk);
    xreset = 1'b1;
    @(negedge clk);

    // Simple ops run back-to-back; multi-cycle ones drain before the next issue.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      if (vecs[i].lat > 1) waitIdle(100);
    end
    waitIdle(10);

    // Divide with an ignored start mid-flight.
    applyStimulus("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
    checkOutput("div_busy_k1", 64'(busy), 64'h1);
    repeat (3) @(negedge clk);
    start = 1'b1; alu = ALU_ADD; rrd1 = 32'h1; rrd2 = 32'h1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("div_busy_mid", 64'(busy), 64'h1);
    waitIdle(100);

    // Special case never raises busy.
    applyStimulus("divu_z2", ALU_DIVU, 32'd9, 32'h0, 32'hFFFF_FFFF, 1);
    checkOutput("special_nobusy", 64'(busy), 64'h0);
    waitIdle(10);

    // rdy stall of 5 cycles during a divide.
    applyStimulus("divu_stall", ALU_DIVU, 32'd1000, 32'd3, 32'd333, 39);
    repeat (10) @(negedge clk);
    rdy = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("stall_busy", 64'(busy), 64'h1);
    rdy = 1'b1;
    waitIdle(100);

    // Reset during a divide aborts it silently.
    applyStimulus("divu_abort", ALU_DIVU, 32'd1000, 32'd7, 32'd142, 34);
    repeat (5) @(negedge clk);
    checkOutput("pre_rst_mulop", 64'(mulop), 64'h1);
    xreset = 1'b0;
    #1;
    sbq.delete();
    checkOutput("mid_rst_rwdat", 64'(rwdat), 64'h0);
    checkOutput("mid_rst_busy",  64'(busy),  64'h0);
    checkOutput("mid_rst_mulop", 64'(mulop), 64'h0);
    checkOutput("mid_rst_cmpl",  64'(cmpl),  64'h0);
    @(negedge clk);
    xreset = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("post_rst_busy", 64'(busy), 64'h0);

    // Block is usable again after the abort.
    applyStimulus("post_rst_mul", ALU_MUL, 32'd6, 32'd7, 32'd42, 2);
    waitIdle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
